// File: rtl/btn_event.sv
// rtl/btn_event.sv - debounced button level to press/release/long/repeat pulses
// Optional auto-repeat is built when BTN_AUTOREPEAT_EN is defined.
module btn_event #(
    parameter int LONG_CYCLES   = 100,
    parameter int REPEAT_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    input  logic enable,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q;
    logic          press_d, release_d, long_d, held_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
    logic repeat_d;
    logic repeat_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        repeat_d  = 1'b0;
`endif
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Counting from 0 here puts long_pulse LONG_CYCLES clocks after press_pulse
                    if (btn_level && !prev_q) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (!btn_level) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                        cnt_d     = '0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d = LONG;
                        long_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                LONG: begin
                    if (!btn_level) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
`ifdef BTN_AUTOREPEAT_EN
                        if (cnt_q == REPEAT_LAST) begin
                            repeat_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
`else
                        cnt_d = '0;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            prev_q        <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            held          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_q        <= btn_level;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            held          <= held_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event.sv
// tb/tb_btn_event.sv - table-driven bench for btn_event (LONG=10, REPEAT=4)
module tb_btn_event;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_level = 1'b1;
    logic enable = 1'b1;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

    btn_event #(.LONG_CYCLES(10), .REPEAT_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_level(btn_level),
        .enable(enable),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse),
        .held(held)
    );

    always #5 clk = ~clk;

    // exp bits: {press, release, long, repeat, held}
    typedef struct {
        logic       btn;
        logic       en;
        logic [4:0] exp;
        int         tag;
    } vec_t;

    vec_t vecs[200];
    int   nvec = 0;
    int   total = 0;
    int   bad = 0;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    function automatic logic [4:0] outs();
        return {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
    endfunction

    task automatic add(input logic btn, input logic en, input logic [4:0] exp, input int tag);
        vecs[nvec].btn = btn;
        vecs[nvec].en  = en;
        vecs[nvec].exp = exp;
        vecs[nvec].tag = tag;
        nvec++;
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got p/r/l/rp/h=%b want %b", name, act, exp);
        end
        total++;
        if (!$onehot0(act[4:1])) begin
            bad++;
            $display("FAIL %s one-pulse: got %b want at most one pulse", name, act);
        end
    endtask

    initial begin
        // test 4: button held through reset release, then clean press/1-cycle tap
        for (int i = 0; i < 3; i++) add(1, 1, 5'b00000, 4);
        add(0, 1, 5'b00000, 4);
        add(1, 1, 5'b10001, 4);
        add(0, 1, 5'b01000, 4);
        add(0, 1, 5'b00000, 4);
        // test 1: short press of 5 cycles
        add(1, 1, 5'b10001, 1);
        for (int i = 1; i < 5; i++) add(1, 1, 5'b00001, 1);
        add(0, 1, 5'b01000, 1);
        add(0, 1, 5'b00000, 1);
        // test 3: release on the long threshold edge
        add(1, 1, 5'b10001, 3);
        for (int i = 1; i < 10; i++) add(1, 1, 5'b00001, 3);
        add(0, 1, 5'b01000, 3);
        add(0, 1, 5'b00000, 3);
        // test 2 / 6: 25-cycle hold
        for (int i = 0; i < 25; i++) begin
            if (i == 0)
                add(1, 1, 5'b10001, 2);
            else if (i == 10)
                add(1, 1, 5'b00101, 2);
            else if (AUTOREP && (i == 14 || i == 18 || i == 22))
                add(1, 1, 5'b00011, 2);
            else
                add(1, 1, 5'b00001, 2);
        end
        add(0, 1, 5'b01000, 2);
        add(0, 1, 5'b00000, 2);
        // test 5: enable dropped in LONG, re-enabled while held
        add(1, 1, 5'b10001, 5);
        for (int i = 1; i < 12; i++) add(1, 1, (i == 10) ? 5'b00101 : 5'b00001, 5);
        for (int i = 0; i < 3; i++) add(1, 0, 5'b00000, 5);
        for (int i = 0; i < 3; i++) add(1, 1, 5'b00000, 5);
        add(0, 1, 5'b00000, 5);
        add(1, 0, 5'b00000, 5);
        add(0, 1, 5'b00000, 5);
        add(1, 1, 5'b10001, 5);
        add(0, 1, 5'b01000, 5);
        add(0, 1, 5'b00000, 5);

        // reset state with button held
        repeat (3) @(posedge clk);
        #1;
        check("reset", outs(), 5'b00000);
        rst_n = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            btn_level = vecs[i].btn;
            enable    = vecs[i].en;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_t%0d", i, vecs[i].tag), outs(), vecs[i].exp);
        end

        // asynchronous reset mid-hold: everything clears at once, no release later
        btn_level = 1'b1;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_press", outs(), 5'b10001);
        @(posedge clk);
        #2;
        check("rst_hold_held", outs(), 5'b00001);
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", outs(), 5'b00000);
        btn_level = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_no_release", outs(), 5'b00000);
        btn_level = 1'b1;
        @(posedge clk);
        #1;
        check("rst_repress", outs(), 5'b10001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
